// File: rtl/dispatch_unit.sv
// dispatch_unit
//   Reader end of the instruction buffer. Pops 16-bit instructions, renames
//   destination registers through a register alias table (RAT), and issues
//   MOV/ADD/LD to the reservation stations. JMP is resolved here and turned
//   into a one-cycle redirect + IB flush toward fetch. HALT parks the unit
//   until reset. The CDB is snooped so pending renames retire into the RAT.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   ib_data_out, ib_empty       IB head word / empty flag
//   ib_pop                      comb, IB advances on posedge when 1
//   ib_flush, branch_taken      registered, high for the redirect cycle
//   branch_target               registered redirect PC
//   rs_ready, rs_tag_free       RS free-slot handshake and its tag
//   rs_valid, rs_op, rs_tag     comb issue request (rs_tag = rs_tag_free)
//   rs_{j,k}_{rdy,val,tag}      operand value or producer tag
//   cdb_valid/tag/data          result broadcast
//   halted                      registered, HALT dispatched

// One RAT entry: rename wins over a same-cycle CDB hit on this entry.
module rat_entry #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rename,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output logic             busy,
  output logic [TAG_W-1:0] src,
  output logic [15:0]      val
);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      src  <= '0;
      val  <= '0;
    end else if (rename) begin
      busy <= 1'b1;
      src  <= rename_tag;
    end else if (cdb_valid && busy && (src == cdb_tag)) begin
      busy <= 1'b0;
      val  <= cdb_data;
    end
  end
endmodule

module dispatch_unit #(
  parameter int NREGS = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      ib_data_out,
  input  logic             ib_empty,
  output logic             ib_pop,
  output logic             ib_flush,
  output logic             branch_taken,
  output logic [15:0]      branch_target,
  input  logic             rs_ready,
  input  logic [TAG_W-1:0] rs_tag_free,
  output logic             rs_valid,
  output logic [3:0]       rs_op,
  output logic [TAG_W-1:0] rs_tag,
  output logic             rs_j_rdy,
  output logic             rs_k_rdy,
  output logic [15:0]      rs_j_val,
  output logic [15:0]      rs_k_val,
  output logic [TAG_W-1:0] rs_j_tag,
  output logic [TAG_W-1:0] rs_k_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output logic             halted
);
  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_HALTED} state_t;

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [15:0]      val;
  } opnd_t;

  state_t state, state_n;

  logic [3:0] op, ra, rb, rt;
  assign op = ib_data_out[15:12];
  assign ra = ib_data_out[11:8];
  assign rb = ib_data_out[7:4];
  assign rt = ib_data_out[3:0];

  logic [NREGS-1:0]            busy_v;
  logic [NREGS-1:0][TAG_W-1:0] src_v;
  logic [NREGS-1:0][15:0]      val_v;

  // Rename is exactly the accepted issue, so it never fires under reset.
  for (genvar i = 0; i < NREGS; i++) begin : g_rat
    rat_entry #(.TAG_W(TAG_W)) u_ent (
      .clk        (clk),
      .reset      (reset),
      .rename     (rs_valid && (rt == 4'(i))),
      .rename_tag (rs_tag_free),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .busy       (busy_v[i]),
      .src        (src_v[i]),
      .val        (val_v[i])
    );
  end

  // Operand lookup with same-cycle CDB bypass; tag is 0 whenever rdy=1.
  function automatic opnd_t lookup(input logic             busy,
                                   input logic [TAG_W-1:0] src,
                                   input logic [15:0]      val,
                                   input logic             cv,
                                   input logic [TAG_W-1:0] ct,
                                   input logic [15:0]      cd);
    opnd_t o;
    o = '0;
    if (!busy) begin
      o.rdy = 1'b1;
      o.val = val;
    end else if (cv && (ct == src)) begin
      o.rdy = 1'b1;
      o.val = cd;
    end else begin
      o.tag = src;
    end
    return o;
  endfunction

  opnd_t opj, opk;

  always_comb begin
    opj = '0;
    opk = '0;
    if (op == OP_MOV) begin
      opj.rdy = 1'b1;
      opj.val = {8'h00, ib_data_out[11:4]};
      opk.rdy = 1'b1;
    end else begin
      opj = lookup(busy_v[ra], src_v[ra], val_v[ra], cdb_valid, cdb_tag, cdb_data);
      opk = lookup(busy_v[rb], src_v[rb], val_v[rb], cdb_valid, cdb_tag, cdb_data);
    end
  end

  assign rs_op    = op;
  assign rs_tag   = rs_tag_free;
  assign rs_j_rdy = opj.rdy;
  assign rs_j_val = opj.val;
  assign rs_j_tag = opj.tag;
  assign rs_k_rdy = opk.rdy;
  assign rs_k_val = opk.val;
  assign rs_k_tag = opk.tag;

  always_comb begin
    state_n  = state;
    ib_pop   = 1'b0;
    rs_valid = 1'b0;
    if (!reset) begin
      case (state)
        S_RUN: begin
          if (!ib_empty) begin
            case (op)
              OP_MOV, OP_ADD, OP_LD: begin
                rs_valid = rs_ready;
                ib_pop   = rs_ready;
              end
              OP_JMP: begin
                ib_pop  = 1'b1;
                state_n = S_REDIRECT;
              end
              OP_HALT: begin
                ib_pop  = 1'b1;
                state_n = S_HALTED;
              end
              default: ib_pop = 1'b1;
            endcase
          end
        end
        S_REDIRECT: state_n = S_RUN;
        S_HALTED:   state_n = S_HALTED;
        default:    state_n = S_RUN;
      endcase
    end
  end

  // Redirect outputs are high exactly while the FSM sits in REDIRECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RUN;
      branch_taken  <= 1'b0;
      ib_flush      <= 1'b0;
      branch_target <= '0;
      halted        <= 1'b0;
    end else begin
      state        <= state_n;
      branch_taken <= (state_n == S_REDIRECT);
      ib_flush     <= (state_n == S_REDIRECT);
      halted       <= (state_n == S_HALTED);
      if (state == S_RUN && state_n == S_REDIRECT)
        branch_target <= {4'h0, ib_data_out[11:0]};
    end
  end
endmodule

// File: tb/tb_dispatch_unit.sv
module tb_dispatch_unit;
  logic        clk = 0;
  logic        reset;
  logic [15:0] ib_data_out;
  logic        ib_empty;
  logic        ib_pop, ib_flush, branch_taken, halted;
  logic [15:0] branch_target;
  logic        rs_ready;
  logic [3:0]  rs_tag_free;
  logic        rs_valid;
  logic [3:0]  rs_op, rs_tag;
  logic        rs_j_rdy, rs_k_rdy;
  logic [15:0] rs_j_val, rs_k_val;
  logic [3:0]  rs_j_tag, rs_k_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;

  int checks = 0;
  int failures = 0;

  dispatch_unit #(.NREGS(16), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .ib_data_out(ib_data_out), .ib_empty(ib_empty),
    .ib_pop(ib_pop), .ib_flush(ib_flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .rs_ready(rs_ready), .rs_tag_free(rs_tag_free),
    .rs_valid(rs_valid), .rs_op(rs_op), .rs_tag(rs_tag), .rs_j_rdy(rs_j_rdy),
    .rs_k_rdy(rs_k_rdy), .rs_j_val(rs_j_val), .rs_k_val(rs_k_val),
    .rs_j_tag(rs_j_tag), .rs_k_tag(rs_k_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] d, input logic e, input logic r, input logic [3:0] t);
    ib_data_out = d;
    ib_empty    = e;
    rs_ready    = r;
    rs_tag_free = t;
  endtask

  task automatic test_reset();
    reset = 1; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    set_in(16'h0251, 0, 1, 4'd2);
    tick(); tick();
    checks++; if (ib_pop !== 1'b0) begin failures++; $display("FAIL rst_pop got=%b exp=0", ib_pop); end
    checks++; if (rs_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", rs_valid); end
    checks++; if ({branch_taken, ib_flush, halted} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {branch_taken, ib_flush, halted}); end
    checks++; if (branch_target !== 16'h0) begin failures++; $display("FAIL rst_target got=%h exp=0000", branch_target); end
    reset = 0;
  endtask

  task automatic test_mov();
    set_in(16'h0251, 0, 1, 4'd2);
    #1;
    checks++; if ({rs_valid, ib_pop} !== 2'b11) begin failures++; $display("FAIL mov_issue got=%b exp=11", {rs_valid, ib_pop}); end
    checks++; if (rs_op !== 4'h0 || rs_tag !== 4'd2) begin failures++; $display("FAIL mov_op_tag got=%h/%h exp=0/2", rs_op, rs_tag); end
    checks++; if (rs_j_rdy !== 1'b1 || rs_j_val !== 16'h0025) begin failures++; $display("FAIL mov_j got=%b/%h exp=1/0025", rs_j_rdy, rs_j_val); end
    checks++; if (rs_k_rdy !== 1'b1 || rs_k_val !== 16'h0) begin failures++; $display("FAIL mov_k got=%b/%h exp=1/0000", rs_k_rdy, rs_k_val); end
    tick();
  endtask

  task automatic test_add_bypass();
    set_in(16'h1123, 0, 1, 4'd3);
    #1;
    checks++; if (rs_j_rdy !== 1'b0 || rs_j_tag !== 4'd2) begin failures++; $display("FAIL add_j_busy got=%b/%h exp=0/2", rs_j_rdy, rs_j_tag); end
    checks++; if (rs_k_rdy !== 1'b1 || rs_k_val !== 16'h0 || rs_k_tag !== 4'd0) begin failures++; $display("FAIL add_k got=%b/%h/%h exp=1/0000/0", rs_k_rdy, rs_k_val, rs_k_tag); end
    checks++; if (rs_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", rs_valid); end
    tick();
    set_in(16'h1114, 0, 1, 4'd4);
    cdb_valid = 1; cdb_tag = 4'd2; cdb_data = 16'h0007;
    #1;
    checks++; if ({rs_j_rdy, rs_k_rdy} !== 2'b11 || rs_j_val !== 16'h7 || rs_k_val !== 16'h7) begin failures++; $display("FAIL bypass got=%b%b %h %h exp=11 0007 0007", rs_j_rdy, rs_k_rdy, rs_j_val, rs_k_val); end
    checks++; if (rs_j_tag !== 4'd0) begin failures++; $display("FAIL bypass_tag got=%h exp=0", rs_j_tag); end
    tick();
    cdb_valid = 0;
    set_in(16'h1156, 0, 0, 4'd5);
    #1;
    checks++; if (rs_j_rdy !== 1'b1 || rs_j_val !== 16'h7) begin failures++; $display("FAIL cdb_commit got=%b/%h exp=1/0007", rs_j_rdy, rs_j_val); end
    checks++; if ({rs_valid, ib_pop} !== 2'b00) begin failures++; $display("FAIL stall_pop got=%b exp=00", {rs_valid, ib_pop}); end
  endtask

  task automatic test_jmp();
    set_in(16'h3040, 0, 1, 4'd8);
    #1;
    checks++; if ({ib_pop, rs_valid} !== 2'b10) begin failures++; $display("FAIL jmp_pop got=%b exp=10", {ib_pop, rs_valid}); end
    tick();
    set_in(16'h0AB6, 0, 1, 4'd9);
    #1;
    checks++; if ({branch_taken, ib_flush} !== 2'b11) begin failures++; $display("FAIL redir_flags got=%b exp=11", {branch_taken, ib_flush}); end
    checks++; if (branch_target !== 16'h0040) begin failures++; $display("FAIL redir_target got=%h exp=0040", branch_target); end
    checks++; if ({ib_pop, rs_valid} !== 2'b00) begin failures++; $display("FAIL redir_pop got=%b exp=00", {ib_pop, rs_valid}); end
    tick();
    checks++; if ({branch_taken, ib_flush} !== 2'b00) begin failures++; $display("FAIL redir_clear got=%b exp=00", {branch_taken, ib_flush}); end
    checks++; if ({ib_pop, rs_valid} !== 2'b11) begin failures++; $display("FAIL resume_pop got=%b exp=11", {ib_pop, rs_valid}); end
    tick();
  endtask

  task automatic test_stall();
    set_in(16'h0CD5, 0, 0, 4'd10);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({ib_pop, rs_valid} !== 2'b00) begin failures++; $display("FAIL stall_%0d got=%b exp=00", c, {ib_pop, rs_valid}); end
      tick();
    end
    set_in(16'h1550, 0, 0, 4'd10);
    #1;
    checks++; if (rs_j_rdy !== 1'b1 || rs_j_val !== 16'h0) begin failures++; $display("FAIL stall_norat got=%b/%h exp=1/0000", rs_j_rdy, rs_j_val); end
    set_in(16'h0CD5, 0, 1, 4'd10);
    #1;
    checks++; if ({ib_pop, rs_valid} !== 2'b11) begin failures++; $display("FAIL stall_release got=%b exp=11", {ib_pop, rs_valid}); end
    tick();
    set_in(16'h0CD5, 1, 1, 4'd11);
    #1;
    checks++; if ({ib_pop, rs_valid} !== 2'b00) begin failures++; $display("FAIL empty_pop got=%b exp=00", {ib_pop, rs_valid}); end
    tick();
    set_in(16'h1550, 0, 0, 4'd11);
    #1;
    checks++; if (rs_j_rdy !== 1'b0 || rs_j_tag !== 4'd10) begin failures++; $display("FAIL stall_rename got=%b/%h exp=0/a", rs_j_rdy, rs_j_tag); end
  endtask

  task automatic test_halt();
    set_in(16'hF000, 0, 1, 4'd1);
    #1;
    checks++; if (ib_pop !== 1'b1) begin failures++; $display("FAIL halt_pop got=%b exp=1", ib_pop); end
    tick();
    set_in(16'h0251, 0, 1, 4'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({halted, ib_pop, rs_valid} !== 3'b100) begin failures++; $display("FAIL halted_%0d got=%b exp=100", c, {halted, ib_pop, rs_valid}); end
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++; if ({halted, ib_pop} !== 2'b01) begin failures++; $display("FAIL halt_reset got=%b exp=01", {halted, ib_pop}); end
    tick();
  endtask

  task automatic test_reset_redirect();
    set_in(16'h0237, 0, 1, 4'd5);
    tick();
    set_in(16'h3123, 0, 1, 4'd6);
    #1;
    checks++; if (ib_pop !== 1'b1) begin failures++; $display("FAIL rr_jmp_pop got=%b exp=1", ib_pop); end
    tick();
    checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL rr_redirect got=%b exp=1", branch_taken); end
    reset = 1;
    #1;
    checks++; if (ib_pop !== 1'b0) begin failures++; $display("FAIL rr_pop_in_reset got=%b exp=0", ib_pop); end
    tick();
    checks++; if ({branch_taken, ib_flush} !== 2'b00 || branch_target !== 16'h0) begin failures++; $display("FAIL rr_clear got=%b/%h exp=00/0000", {branch_taken, ib_flush}, branch_target); end
    reset = 0;
    for (int r = 0; r < 16; r++) begin
      logic [3:0] rr;
      rr = 4'(r);
      set_in({4'h1, rr, rr, 4'h0}, 0, 0, 4'd0);
      #1;
      checks++; if (rs_j_rdy !== 1'b1 || rs_j_val !== 16'h0) begin failures++; $display("FAIL rr_rat_r%0d got=%b/%h exp=1/0000", r, rs_j_rdy, rs_j_val); end
    end
  endtask

  // Reference model: architectural view of the RAT plus the dispatcher mode.
  logic        m_busy [16];
  logic [3:0]  m_src  [16];
  logic [15:0] m_val  [16];
  int          m_mode;   // 0 running, 1 redirecting, 2 halted
  logic        m_bt, m_halt;
  logic [15:0] m_tgt;

  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin m_busy[r] = 0; m_src[r] = 0; m_val[r] = 0; end
    m_mode = 0; m_bt = 0; m_halt = 0; m_tgt = 0;
  endtask

  task automatic test_random();
    reset = 1; cdb_valid = 0;
    tick();
    reset = 0;
    model_clear();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int          pick;
      logic [3:0]  o, a, b, d;
      logic        e_pop, e_valid, ej_rdy, ek_rdy;
      logic [3:0]  ej_tag, ek_tag;
      logic [15:0] ej_val, ek_val;
      int          k;
      pick = $urandom_range(0, 99);
      if (pick < 30) o = 4'h0;
      else if (pick < 58) o = 4'h1;
      else if (pick < 78) o = 4'h2;
      else if (pick < 86) o = 4'h3;
      else if (pick < 97) o = 4'($urandom_range(4, 14));
      else o = 4'hF;
      set_in({o, 12'($urandom())}, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0), 4'($urandom()));
      k = $urandom_range(0, 15);
      cdb_valid = $urandom_range(0, 1);
      cdb_tag   = m_busy[k] ? m_src[k] : 4'($urandom());
      cdb_data  = 16'($urandom());
      reset     = (m_mode == 2 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 79) == 0);
      a = ib_data_out[11:8]; b = ib_data_out[7:4]; d = ib_data_out[3:0];

      e_pop = 0; e_valid = 0;
      if (!reset && m_mode == 0 && !ib_empty) begin
        if (o <= 4'h2) begin e_pop = rs_ready; e_valid = rs_ready; end
        else e_pop = 1;
      end

      ej_rdy = 1; ej_tag = 0; ej_val = 0; ek_rdy = 1; ek_tag = 0; ek_val = 0;
      if (o == 4'h0) ej_val = {8'h00, ib_data_out[11:4]};
      else begin
        if (!m_busy[a]) ej_val = m_val[a];
        else if (cdb_valid && cdb_tag == m_src[a]) ej_val = cdb_data;
        else begin ej_rdy = 0; ej_tag = m_src[a]; end
        if (!m_busy[b]) ek_val = m_val[b];
        else if (cdb_valid && cdb_tag == m_src[b]) ek_val = cdb_data;
        else begin ek_rdy = 0; ek_tag = m_src[b]; end
      end
      #1;
      checks++; if ({ib_pop, rs_valid} !== {e_pop, e_valid}) begin failures++; $display("FAIL rnd_hs cyc=%0d got=%b exp=%b", cyc, {ib_pop, rs_valid}, {e_pop, e_valid}); end
      checks++; if ({branch_taken, ib_flush, halted} !== {m_bt, m_bt, m_halt} || branch_target !== m_tgt) begin failures++; $display("FAIL rnd_regs cyc=%0d got=%b/%h exp=%b/%h", cyc, {branch_taken, ib_flush, halted}, branch_target, {m_bt, m_bt, m_halt}, m_tgt); end
      if (!reset && m_mode == 0 && !ib_empty && o <= 4'h2) begin
        checks++;
        if (rs_op !== o || rs_tag !== rs_tag_free || rs_j_rdy !== ej_rdy || rs_j_tag !== ej_tag ||
            rs_k_rdy !== ek_rdy || rs_k_tag !== ek_tag || (ej_rdy && rs_j_val !== ej_val) ||
            (ek_rdy && rs_k_val !== ek_val)) begin
          failures++;
          $display("FAIL rnd_opnd cyc=%0d got=%h %b%h%h %b%h%h exp=%h %b%h%h %b%h%h", cyc, rs_op,
                   rs_j_rdy, rs_j_tag, rs_j_val, rs_k_rdy, rs_k_tag, rs_k_val, o,
                   ej_rdy, ej_tag, ej_val, ek_rdy, ek_tag, ek_val);
        end
      end

      if (reset) model_clear();
      else begin
        if (cdb_valid)
          for (int r = 0; r < 16; r++)
            if (m_busy[r] && m_src[r] == cdb_tag) begin m_busy[r] = 0; m_val[r] = cdb_data; end
        if (e_valid) begin m_busy[d] = 1; m_src[d] = rs_tag_free; end
        if (m_mode == 1) m_mode = 0;
        else if (m_mode == 0 && !ib_empty && o == 4'h3) begin m_mode = 1; m_tgt = {4'h0, ib_data_out[11:0]}; end
        else if (m_mode == 0 && !ib_empty && o == 4'hF) m_mode = 2;
        m_bt = (m_mode == 1);
        m_halt = (m_mode == 2);
      end
      tick();
    end
    reset = 0; cdb_valid = 0;
  endtask

  initial begin
    test_reset();
    test_mov();
    test_add_bypass();
    test_jmp();
    test_stall();
    test_halt();
    test_reset_redirect();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
